// File: rtl/qdrc_port_arb_pkg.sv
// Shared constants, helper function and types for the QDR multi-port arbiter.
package qdrc_port_arb_pkg;

  localparam int NUM_PORTS_MIN = 2;
  localparam int NUM_PORTS_MAX = 8;
  localparam int CMD_GAP_MIN   = 1;
  localparam int CMD_GAP_MAX   = 4;

  // Ceiling log2 for constant sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Gap counter only has to reach CMD_GAP_MAX-1.
  localparam int GAP_CNT_WIDTH = clog2(CMD_GAP_MAX);

  // Kind of command granted in the current cycle.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RD,
    CMD_WR
  } cmd_e;

endpackage

// File: rtl/qdrc_tag_fifo.sv
// In-order tag FIFO: remembers which port issued each outstanding read.
module qdrc_tag_fifo
  import qdrc_port_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Tag storage.
  // NOTE: the array has no reset; an entry is only read after it has been written, and
  // leaving it out of reset lets it map onto plain storage cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/qdrc_port_arb.sv
// Multi-port front end for the QDR controller: round-robin arbitration of user
// read/write channels onto the single controller interface, with in-order read return.
module qdrc_port_arb
  import qdrc_port_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int ADDR_WIDTH = 21,
  parameter int CMD_GAP    = 1,
  parameter int MAX_RD_OUT = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             port_rd_strb,
  input  logic [NUM_PORTS-1:0]             port_wr_strb,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wr_data,
  input  logic [NUM_PORTS*BW_WIDTH-1:0]    port_wr_be,
  output logic [NUM_PORTS-1:0]             port_ack,
  output logic [DATA_WIDTH-1:0]            port_rd_data,
  output logic [NUM_PORTS-1:0]             port_rd_dvld,
  input  logic                             phy_rdy,
  output logic                             qdr_rd_strb,
  output logic                             qdr_wr_strb,
  output logic [ADDR_WIDTH-1:0]            qdr_addr,
  output logic [DATA_WIDTH-1:0]            qdr_wr_data,
  output logic [BW_WIDTH-1:0]              qdr_wr_be,
  input  logic [DATA_WIDTH-1:0]            qdr_rd_data,
  input  logic                             qdr_rd_dvld,
  output logic [clog2(MAX_RD_OUT):0]       rd_outstanding,
  output logic                             ret_err
);

  localparam int PW = (clog2(NUM_PORTS) > 0) ? clog2(NUM_PORTS) : 1;
  localparam int CW = clog2(MAX_RD_OUT) + 1;
  localparam logic [GAP_CNT_WIDTH-1:0] GAP_LOAD = GAP_CNT_WIDTH'(CMD_GAP - 1);

  logic [PW-1:0]            rr_ptr;
  logic [GAP_CNT_WIDTH-1:0] gap_cnt;
  logic                     issue_ok;
  logic [NUM_PORTS-1:0]     eligible;
  logic                     grant_vld;
  logic [PW-1:0]            grant_idx;
  logic [PW:0]              scan_sum;
  cmd_e                     grant_cmd;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [PW-1:0]            fifo_head;
  logic [CW-1:0]            fifo_count;

  // Nothing issues in reset, before calibration, or while the spacing gap runs.
  assign issue_ok = reset_n && phy_rdy && (gap_cnt == '0);

  // Per-port eligibility: a read also needs a free tag slot.
  // NOTE: every combinational output gets a value on every path, so no latches are inferred.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = issue_ok && (port_wr_strb[p] || (port_rd_strb[p] && !fifo_full));
    end
  end

  // Round-robin scan from rr_ptr with wrap; the first eligible port wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(NUM_PORTS)) scan_sum = scan_sum - (PW+1)'(NUM_PORTS);
      if (!grant_vld && eligible[scan_sum[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_sum[PW-1:0];
      end
    end
  end

  // Decode the winner (write beats read on the same port) and drive the one-hot ack.
  always_comb begin
    grant_cmd = CMD_NONE;
    if (grant_vld) grant_cmd = port_wr_strb[grant_idx] ? CMD_WR : CMD_RD;
    port_ack = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_ack[p] = grant_vld && (grant_idx == PW'(p));
    end
  end

  // Arbitration state: pointer moves past the winner; gap counter spaces issued commands.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr  <= '0;
      gap_cnt <= '0;
    end else if (grant_vld) begin
      rr_ptr  <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_CNT_WIDTH'(1);
    end
  end

  // Issue registers: strobes pulse one cycle; address/data/be hold between grants.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      qdr_rd_strb <= 1'b0;
      qdr_wr_strb <= 1'b0;
      qdr_addr    <= '0;
      qdr_wr_data <= '0;
      qdr_wr_be   <= '0;
    end else begin
      qdr_rd_strb <= (grant_cmd == CMD_RD);
      qdr_wr_strb <= (grant_cmd == CMD_WR);
      if (grant_vld) begin
        qdr_addr    <= port_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        qdr_wr_data <= port_wr_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        qdr_wr_be   <= port_wr_be[int'(grant_idx)*BW_WIDTH +: BW_WIDTH];
      end
    end
  end

  // Tag push on a read grant; pop only when a tag is actually pending.
  assign fifo_push = (grant_cmd == CMD_RD);
  assign fifo_pop  = qdr_rd_dvld && !fifo_empty;

  qdrc_tag_fifo #(
    .WIDTH (PW),
    .DEPTH (MAX_RD_OUT)
  ) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (grant_idx),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_outstanding = fifo_count;

  // Return demux: route data to the head-of-queue port; flag returns with no pending tag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      port_rd_data <= '0;
      port_rd_dvld <= '0;
      ret_err      <= 1'b0;
    end else begin
      port_rd_dvld <= '0;
      if (fifo_pop) begin
        port_rd_data            <= qdr_rd_data;
        port_rd_dvld[fifo_head] <= 1'b1;
      end
      if (qdr_rd_dvld && fifo_empty) ret_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qdrc_port_arb.sv
// Testbench for qdrc_port_arb: table-driven arbitration vectors, directed corner-case
// sequences, and a randomized run against a queue-based reference model.
module tb_qdrc_port_arb;

  localparam int N    = 4;
  localparam int DW   = 36;
  localparam int BW   = 4;
  localparam int AW   = 21;
  localparam int MAXR = 16;
  localparam int CW   = 5;
  localparam int GAP  = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      rd_strb;
  logic [N-1:0]      wr_strb;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N*BW-1:0]   be;
  logic              phy_rdy;
  logic [DW-1:0]     rd_data_in;
  logic              dvld_in;

  logic [N-1:0]      port_ack,     port_ack_g2;
  logic [DW-1:0]     port_rd_data, port_rd_data_g2;
  logic [N-1:0]      port_rd_dvld, port_rd_dvld_g2;
  logic              qdr_rd_strb,  qdr_rd_strb_g2;
  logic              qdr_wr_strb,  qdr_wr_strb_g2;
  logic [AW-1:0]     qdr_addr,     qdr_addr_g2;
  logic [DW-1:0]     qdr_wr_data,  qdr_wr_data_g2;
  logic [BW-1:0]     qdr_wr_be,    qdr_wr_be_g2;
  logic [CW-1:0]     rd_outstanding, rd_outstanding_g2;
  logic              ret_err,      ret_err_g2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  qdrc_port_arb #(
    .NUM_PORTS(N), .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW),
    .CMD_GAP(GAP), .MAX_RD_OUT(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .port_rd_strb(rd_strb), .port_wr_strb(wr_strb), .port_addr(addr),
    .port_wr_data(wdata), .port_wr_be(be), .port_ack(port_ack),
    .port_rd_data(port_rd_data), .port_rd_dvld(port_rd_dvld), .phy_rdy(phy_rdy),
    .qdr_rd_strb(qdr_rd_strb), .qdr_wr_strb(qdr_wr_strb), .qdr_addr(qdr_addr),
    .qdr_wr_data(qdr_wr_data), .qdr_wr_be(qdr_wr_be), .qdr_rd_data(rd_data_in),
    .qdr_rd_dvld(dvld_in), .rd_outstanding(rd_outstanding), .ret_err(ret_err)
  );

  qdrc_port_arb #(
    .NUM_PORTS(N), .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW),
    .CMD_GAP(2), .MAX_RD_OUT(MAXR)
  ) dut_g2 (
    .clk(clk), .reset_n(reset_n),
    .port_rd_strb(rd_strb), .port_wr_strb(wr_strb), .port_addr(addr),
    .port_wr_data(wdata), .port_wr_be(be), .port_ack(port_ack_g2),
    .port_rd_data(port_rd_data_g2), .port_rd_dvld(port_rd_dvld_g2), .phy_rdy(phy_rdy),
    .qdr_rd_strb(qdr_rd_strb_g2), .qdr_wr_strb(qdr_wr_strb_g2), .qdr_addr(qdr_addr_g2),
    .qdr_wr_data(qdr_wr_data_g2), .qdr_wr_be(qdr_wr_be_g2), .qdr_rd_data(rd_data_in),
    .qdr_rd_dvld(dvld_in), .rd_outstanding(rd_outstanding_g2), .ret_err(ret_err_g2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    rd_strb    = '0;
    wr_strb    = '0;
    dvld_in    = 1'b0;
    rd_data_in = '0;
    phy_rdy    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] wr;
    logic         phy;
    logic [N-1:0] exp_ack;
  } arb_vec_t;

  arb_vec_t vecs[16];

  // Reference model state for the randomized run.
  int           m_ptr, m_gap, g, last_ret;
  int           tagq[$];
  int           ret_q[$];
  logic [N-1:0] pend_rd, pend_wr, exp_ack;
  logic         e_rd, e_wr, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [BW-1:0] e_be;
  logic [N-1:0]  e_dvld;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    logic [BW-1:0] t_be;

    vecs[0]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000};
    vecs[8]  = '{4'b0001, 1'b1, 4'b0001};
    vecs[9]  = '{4'b1001, 1'b1, 4'b1000};
    vecs[10] = '{4'b0110, 1'b1, 4'b0010};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000};
    vecs[12] = '{4'b0011, 1'b1, 4'b0001};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000};
    vecs[14] = '{4'b1100, 1'b1, 4'b0100};
    vecs[15] = '{4'b0101, 1'b1, 4'b0001};

    for (int p = 0; p < N; p++) begin
      addr[p*AW +: AW]  = AW'(32'h100 + p);
      wdata[p*DW +: DW] = DW'(32'hA00 + p);
      be[p*BW +: BW]    = BW'(p + 1);
    end

    // Reset with every strobe raised.
    reset_n = 1'b0; rd_strb = '1; wr_strb = '1; phy_rdy = 1'b1;
    dvld_in = 1'b0; rd_data_in = '0;
    tick();
    check("rst_ack", 64'(port_ack), 64'h0);
    check("rst_qdr_rd", 64'(qdr_rd_strb), 64'h0);
    check("rst_qdr_wr", 64'(qdr_wr_strb), 64'h0);
    check("rst_outstanding", 64'(rd_outstanding), 64'h0);
    check("rst_ret_err", 64'(ret_err), 64'h0);
    check("rst_rd_dvld", 64'(port_rd_dvld), 64'h0);
    check("rst_qdr_addr", 64'(qdr_addr), 64'h0);
    tick();
    check("rst_ack2", 64'(port_ack), 64'h0);
    check("rst_qdr_wr2", 64'(qdr_wr_strb), 64'h0);

    // Round-robin table.
    do_reset();
    t_addr = '0; t_data = '0; t_be = '0;
    for (int i = 0; i < 16; i++) begin
      wr_strb = vecs[i].wr;
      phy_rdy = vecs[i].phy;
      #1;
      check("rr_ack", 64'(port_ack), 64'(vecs[i].exp_ack));
      tick();
      for (int p = 0; p < N; p++) begin
        if (vecs[i].exp_ack[p]) begin
          t_addr = AW'(32'h100 + p);
          t_data = DW'(32'hA00 + p);
          t_be   = BW'(p + 1);
        end
      end
      check("rr_qdr_wr", 64'(qdr_wr_strb), 64'(|vecs[i].exp_ack));
      check("rr_qdr_rd", 64'(qdr_rd_strb), 64'h0);
      check("rr_qdr_addr", 64'(qdr_addr), 64'(t_addr));
      check("rr_qdr_data", 64'(qdr_wr_data), 64'(t_data));
      check("rr_qdr_be", 64'(qdr_wr_be), 64'(t_be));
    end
    wr_strb = '0; phy_rdy = 1'b1;

    // Read routing: port2 then port0, returned in order.
    do_reset();
    addr[2*AW +: AW] = 21'h00010;
    addr[0*AW +: AW] = 21'h1FFFF;
    rd_strb = 4'b0100; #1;
    check("rt_ack_p2", 64'(port_ack), 64'h4);
    tick(); rd_strb = '0;
    check("rt_issue_rd", 64'(qdr_rd_strb), 64'h1);
    check("rt_issue_addr", 64'(qdr_addr), 64'h00010);
    check("rt_out1", 64'(rd_outstanding), 64'h1);
    rd_strb = 4'b0001; #1;
    check("rt_ack_p0", 64'(port_ack), 64'h1);
    tick(); rd_strb = '0;
    check("rt_issue_addr2", 64'(qdr_addr), 64'h1FFFF);
    check("rt_out2", 64'(rd_outstanding), 64'h2);
    repeat (8) tick();
    dvld_in = 1'b1; rd_data_in = 36'h0_00AB_2222;
    tick();
    rd_data_in = 36'h0_00CD_1111;
    check("rt_dvld_p2", 64'(port_rd_dvld), 64'h4);
    check("rt_data_p2", 64'(port_rd_data), 64'h00AB_2222);
    check("rt_out_after1", 64'(rd_outstanding), 64'h1);
    tick(); dvld_in = 1'b0;
    check("rt_dvld_p0", 64'(port_rd_dvld), 64'h1);
    check("rt_data_p0", 64'(port_rd_data), 64'h00CD_1111);
    check("rt_out_after2", 64'(rd_outstanding), 64'h0);
    tick();
    check("rt_dvld_idle", 64'(port_rd_dvld), 64'h0);
    check("rt_err_clean", 64'(ret_err), 64'h0);

    // Full tag FIFO.
    do_reset();
    for (int i = 0; i < MAXR; i++) begin
      rd_strb = 4'b0001; #1;
      check("full_fill_ack", 64'(port_ack), 64'h1);
      tick();
    end
    check("full_out16", 64'(rd_outstanding), 64'd16);
    wr_strb = 4'b0010; #1;
    check("full_wr_acked", 64'(port_ack), 64'h2);
    tick(); wr_strb = '0;
    check("full_wr_issued", 64'(qdr_wr_strb), 64'h1);
    check("full_no_rd", 64'(qdr_rd_strb), 64'h0);
    check("full_out_hold", 64'(rd_outstanding), 64'd16);
    #1;
    check("full_rd_blocked", 64'(port_ack), 64'h0);
    dvld_in = 1'b1; rd_data_in = 36'h1_2345_6789;
    tick(); dvld_in = 1'b0;
    check("full_pop_out", 64'(rd_outstanding), 64'd15);
    check("full_pop_dvld", 64'(port_rd_dvld), 64'h1);
    check("full_pop_data", 64'(port_rd_data), 64'h1_2345_6789);
    dvld_in = 1'b1; rd_data_in = 36'h0_0000_0042; #1;
    check("full_rd_after_pop", 64'(port_ack), 64'h1);
    tick(); dvld_in = 1'b0; rd_strb = '0;
    check("pushpop_out", 64'(rd_outstanding), 64'd15);
    check("pushpop_dvld", 64'(port_rd_dvld), 64'h1);
    check("pushpop_issue", 64'(qdr_rd_strb), 64'h1);

    // CMD_GAP=2 instance: write then read on port1, two cycles apart.
    do_reset();
    wr_strb = 4'b0010; rd_strb = 4'b0010; #1;
    check("gap_wr_ack", 64'(port_ack_g2), 64'h2);
    tick(); wr_strb = '0;
    check("gap_wr_issue", 64'(qdr_wr_strb_g2), 64'h1);
    check("gap_wr_not_rd", 64'(qdr_rd_strb_g2), 64'h0);
    #1;
    check("gap_hold_ack", 64'(port_ack_g2), 64'h0);
    tick();
    check("gap_idle_rd", 64'(qdr_rd_strb_g2), 64'h0);
    check("gap_idle_wr", 64'(qdr_wr_strb_g2), 64'h0);
    #1;
    check("gap_rd_ack", 64'(port_ack_g2), 64'h2);
    tick(); rd_strb = '0;
    check("gap_rd_issue", 64'(qdr_rd_strb_g2), 64'h1);
    check("gap_rd_not_wr", 64'(qdr_wr_strb_g2), 64'h0);

    // Return with nothing pending, then a calibration stall with a return in flight.
    do_reset();
    dvld_in = 1'b1; rd_data_in = 36'h0_0BAD_0BAD;
    tick(); dvld_in = 1'b0;
    check("err_set", 64'(ret_err), 64'h1);
    check("err_no_dvld", 64'(port_rd_dvld), 64'h0);
    check("err_out", 64'(rd_outstanding), 64'h0);
    rd_strb = 4'b1000; #1;
    check("stall_rd_ack", 64'(port_ack), 64'h8);
    tick(); rd_strb = '0;
    check("err_sticky", 64'(ret_err), 64'h1);
    phy_rdy = 1'b0; wr_strb = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin dvld_in = 1'b1; rd_data_in = 36'h0_0000_7777; end
      #1;
      check("stall_no_ack", 64'(port_ack), 64'h0);
      tick(); dvld_in = 1'b0;
      check("stall_no_wr", 64'(qdr_wr_strb), 64'h0);
      if (k == 2) begin
        check("stall_ret_dvld", 64'(port_rd_dvld), 64'h8);
        check("stall_ret_data", 64'(port_rd_data), 64'h7777);
        check("stall_ret_out", 64'(rd_outstanding), 64'h0);
      end
    end
    phy_rdy = 1'b1; #1;
    check("stall_resume_ack", 64'(port_ack), 64'h1);
    tick(); wr_strb = '0;

    // Randomized run against the reference model.
    do_reset();
    m_ptr = 0; m_gap = 0; last_ret = -1;
    tagq.delete(); ret_q.delete();
    pend_rd = '0; pend_wr = '0;
    e_rd = 1'b0; e_wr = 1'b0; e_err = 1'b0; e_addr = '0; e_wdata = '0;
    e_rdata = '0; e_be = '0; e_dvld = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend_rd[p] && !pend_wr[p] && $urandom_range(0, 2) == 0) begin
          int k;
          k = $urandom_range(0, 2);
          pend_rd[p] = (k != 1);
          pend_wr[p] = (k != 0);
          addr[p*AW +: AW]  = AW'($urandom());
          wdata[p*DW +: DW] = DW'({$urandom(), $urandom()});
          be[p*BW +: BW]    = BW'($urandom());
        end
      end
      rd_strb = pend_rd;
      wr_strb = pend_wr;
      phy_rdy = ($urandom_range(0, 9) != 0);
      dvld_in = 1'b0;
      if (ret_q.size() > 0 && ret_q[0] == c) begin
        void'(ret_q.pop_front());
        dvld_in    = 1'b1;
        rd_data_in = DW'({$urandom(), $urandom()});
      end
      #1;
      g = -1;
      if (phy_rdy && m_gap == 0) begin
        for (int i = 0; i < N; i++) begin
          int p;
          p = (m_ptr + i) % N;
          if (g < 0 && (wr_strb[p] || (rd_strb[p] && tagq.size() < MAXR))) g = p;
        end
      end
      exp_ack = '0;
      if (g >= 0) exp_ack[g] = 1'b1;
      check("rand_ack", 64'(port_ack), 64'(exp_ack));
      e_rd = (g >= 0) && !wr_strb[g];
      e_wr = (g >= 0) && wr_strb[g];
      if (g >= 0) begin
        e_addr  = addr[g*AW +: AW];
        e_wdata = wdata[g*DW +: DW];
        e_be    = be[g*BW +: BW];
      end
      e_dvld = '0;
      if (dvld_in) begin
        if (tagq.size() > 0) begin
          e_dvld[tagq.pop_front()] = 1'b1;
          e_rdata = rd_data_in;
        end else begin
          e_err = 1'b1;
        end
      end
      if (e_rd) begin
        int r;
        tagq.push_back(g);
        r = c + 1 + $urandom_range(0, 30);
        if (r <= last_ret) r = last_ret + 1;
        last_ret = r;
        ret_q.push_back(r);
      end
      if (g >= 0) begin
        m_gap = GAP - 1;
        m_ptr = (g + 1) % N;
        if (pend_wr[g]) pend_wr[g] = 1'b0;
        else            pend_rd[g] = 1'b0;
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end
      tick();
      check("rand_qdr_rd", 64'(qdr_rd_strb), 64'(e_rd));
      check("rand_qdr_wr", 64'(qdr_wr_strb), 64'(e_wr));
      check("rand_qdr_addr", 64'(qdr_addr), 64'(e_addr));
      check("rand_qdr_data", 64'(qdr_wr_data), 64'(e_wdata));
      check("rand_qdr_be", 64'(qdr_wr_be), 64'(e_be));
      check("rand_rd_dvld", 64'(port_rd_dvld), 64'(e_dvld));
      check("rand_rd_data", 64'(port_rd_data), 64'(e_rdata));
      check("rand_outstanding", 64'(rd_outstanding), 64'(tagq.size()));
      check("rand_ret_err", 64'(ret_err), 64'(e_err));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
